// File: rtl/mips_pkg.sv
// Shared load-path definitions: size encodings, controller FSM states, default timeout.
// Imported by load_ext_ctrl and load_lane_ext.
package mips_pkg;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    localparam int TIMEOUT_CYC_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } ld_state_t;

endpackage

// File: rtl/load_lane_ext.sv
// Big-endian lane select plus zero/sign extension of a returned memory word.
// Purely combinational: zero latency, no backpressure.
module load_lane_ext
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8  = 8'h00;
        data_o = rdata_i;
        // Byte offset 0 is the most significant byte of the word.
        case (off_i)
            2'd0:    lane8 = rdata_i[31:24];
            2'd1:    lane8 = rdata_i[23:16];
            2'd2:    lane8 = rdata_i[15:8];
            default: lane8 = rdata_i[7:0];
        endcase
        lane16 = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
        case (size_i)
            LD_BYTE: data_o = uns_i ? {24'h000000, lane8}  : {{24{lane8[7]}}, lane8};
            LD_HALF: data_o = uns_i ? {16'h0000, lane16}   : {{16{lane16[15]}}, lane16};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_ext_ctrl.sv
// Load controller: one request at a time, word read, lane select/extend, error on illegal or timeout.
// Latency 2 cycles min (accept, read, respond); req_ready low until response handshake. Macro LOAD_ALIGN_EXC_EN makes misalignment an error.
module load_ext_ctrl
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    ld_state_t   state_q, state_d;
    logic [29:0] waddr_q, waddr_d;
    logic [1:0]  off_q,   off_d;
    logic [1:0]  size_q,  size_d;
    logic        uns_q,   uns_d;
    logic [4:0]  rd_q,    rd_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic [31:0] data_q,  data_d;
    logic        err_q,   err_d;

    logic        req_illegal;
    logic [1:0]  req_off;
    logic [7:0]  cnt_inc;
    logic [31:0] ext_data;

    always_comb begin
        req_illegal = (req_size == 2'b11);
`ifdef LOAD_ALIGN_EXC_EN
        if ((req_size == LD_HALF && req_addr[0]) ||
            (req_size == LD_WORD && req_addr[1:0] != 2'b00)) begin
            req_illegal = 1'b1;
        end
`endif
        // Natural alignment of the lane offset; only matters when misalignment is not trapped.
        case (req_size)
            LD_HALF: req_off = {req_addr[1], 1'b0};
            LD_WORD: req_off = 2'b00;
            default: req_off = req_addr[1:0];
        endcase
    end

    load_lane_ext u_lane (
        .rdata_i (mem_rdata),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .data_o  (ext_data)
    );

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    waddr_d = req_addr[31:2];
                    off_d   = req_off;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    rd_d    = req_rd;
                    if (req_illegal) begin
                        err_d   = 1'b1;
                        data_d  = 32'h0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // An ack on the final allowed cycle still beats the timeout.
                if (mem_ack) begin
                    data_d  = ext_data;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_LIM) begin
                        data_d  = 32'h0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            waddr_q <= 30'h0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rd_q    <= 5'h0;
            cnt_q   <= 8'd0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_rd_en = (state_q == ST_WAIT);
    assign rsp_valid = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign mem_addr  = {waddr_q, 2'b00};
    assign rsp_data  = data_q;
    assign rsp_rd    = rd_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_ext_ctrl.sv
// Directed bench for load_ext_ctrl with TIMEOUT_CYC = 4 and hand-computed expectations.
module tb_load_ext_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    load_ext_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_rd       (req_rd),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_rd       (rsp_rd),
        .rsp_err      (rsp_err),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives a request; in cycle 1+dly the memory acks with rdata. Inputs change on negedges.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [4:0] rd, input logic [31:0] rdata,
                           input int dly, input bit illegal, input logic [31:0] exp_maddr,
                           input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        chk({tag, ":req_ready"}, {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_size = size; req_unsigned = uns; req_rd = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (illegal) begin
            chk({tag, ":c1_rsp_valid"}, {31'h0, rsp_valid}, 32'd1);
            chk({tag, ":c1_mem_rd_en"}, {31'h0, mem_rd_en}, 32'd0);
        end else begin
            chk({tag, ":c1_rsp_valid"}, {31'h0, rsp_valid}, 32'd0);
            chk({tag, ":c1_mem_rd_en"}, {31'h0, mem_rd_en}, 32'd1);
            chk({tag, ":mem_addr"}, mem_addr, exp_maddr);
            repeat (dly) @(negedge clk);
            mem_ack = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 32'h0;
            chk({tag, ":rsp_valid"}, {31'h0, rsp_valid}, 32'd1);
            chk({tag, ":resp_mem_rd_en"}, {31'h0, mem_rd_en}, 32'd0);
        end
        chk({tag, ":rsp_data"}, rsp_data, exp_data);
        chk({tag, ":rsp_err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        chk({tag, ":rsp_rd"}, {27'h0, rsp_rd}, {27'h0, rd});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, ":after_hs_valid"}, {31'h0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_size = 2'b00;
        req_unsigned = 1'b0; req_rd = 5'd0; rsp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst:req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst:rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst:mem_rd_en", {31'h0, mem_rd_en}, 32'd0);
        chk("rst:busy", {31'h0, busy}, 32'd0);
        chk("rst:rsp_data", rsp_data, 32'h0);
        chk("rst:mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;

        // Byte loads from 0x12F45678
        do_load("lbu_o1", 32'h0000_1001, 2'b00, 1'b1, 5'd3, 32'h12F45678, 0, 1'b0, 32'h1000, 32'h0000_00F4, 1'b0);
        do_load("lb_o1",  32'h0000_1001, 2'b00, 1'b0, 5'd4, 32'h12F45678, 1, 1'b0, 32'h1000, 32'hFFFF_FFF4, 1'b0);
        do_load("lb_o0",  32'h0000_1000, 2'b00, 1'b0, 5'd5, 32'h12F45678, 0, 1'b0, 32'h1000, 32'h0000_0012, 1'b0);
        do_load("lb_o3",  32'h0000_2003, 2'b00, 1'b0, 5'd6, 32'h12F45678, 2, 1'b0, 32'h2000, 32'h0000_0078, 1'b0);
        // Half loads from 0x12348001
        do_load("lh_2",   32'h0000_1002, 2'b01, 1'b0, 5'd7, 32'h12348001, 0, 1'b0, 32'h1000, 32'hFFFF_8001, 1'b0);
        do_load("lhu_2",  32'h0000_1002, 2'b01, 1'b1, 5'd8, 32'h12348001, 0, 1'b0, 32'h1000, 32'h0000_8001, 1'b0);
        do_load("lh_0",   32'h0000_1000, 2'b01, 1'b0, 5'd9, 32'h8001_1234, 0, 1'b0, 32'h1000, 32'hFFFF_8001, 1'b0);
        do_load("lw",     32'h0000_4004, 2'b10, 1'b1, 5'd10, 32'h8765_4321, 0, 1'b0, 32'h4004, 32'h8765_4321, 1'b0);
        do_load("size11", 32'h0000_1000, 2'b11, 1'b0, 5'd11, 32'h0, 0, 1'b1, 32'h0, 32'h0, 1'b1);
`ifdef LOAD_ALIGN_EXC_EN
        do_load("lh_mis", 32'h0000_1001, 2'b01, 1'b0, 5'd12, 32'h0, 0, 1'b1, 32'h0, 32'h0, 1'b1);
        do_load("lw_mis", 32'h0000_1002, 2'b10, 1'b0, 5'd13, 32'h0, 0, 1'b1, 32'h0, 32'h0, 1'b1);
`else
        do_load("lh_mis", 32'h0000_1001, 2'b01, 1'b0, 5'd12, 32'h12348001, 0, 1'b0, 32'h1000, 32'h0000_1234, 1'b0);
        do_load("lw_mis", 32'h0000_1002, 2'b10, 1'b0, 5'd13, 32'hCAFE_F00D, 0, 1'b0, 32'h1000, 32'hCAFE_F00D, 1'b0);
`endif

        // Timeout: 4 WAIT cycles without ack, then an error response
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_5000; req_size = 2'b10; req_rd = 5'd14;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to:wait%0d_rd_en", i), {31'h0, mem_rd_en}, 32'd1);
            chk($sformatf("to:wait%0d_valid", i), {31'h0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("to:rsp_valid", {31'h0, rsp_valid}, 32'd1);
        chk("to:rsp_err", {31'h0, rsp_err}, 32'd1);
        chk("to:rsp_data", rsp_data, 32'h0);
        chk("to:rsp_rd", {27'h0, rsp_rd}, 32'd14);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("to:late_ack_valid", {31'h0, rsp_valid}, 32'd0);
        chk("to:late_ack_busy", {31'h0, busy}, 32'd0);
        chk("to:late_ack_data", rsp_data, 32'h0);

        // Ack on the timeout cycle wins
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_5000; req_size = 2'b10; req_rd = 5'd15;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("race:rd_en", {31'h0, mem_rd_en}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("race:rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("race:rsp_data", rsp_data, 32'h0BAD_CAFE);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Backpressure: response held, second request waits for the handshake
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_3000; req_size = 2'b10; req_rd = 5'd7;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0F0F;
        @(negedge clk);
        mem_ack = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_3003; req_size = 2'b00; req_unsigned = 1'b1; req_rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp%0d:valid", i), {31'h0, rsp_valid}, 32'd1);
            chk($sformatf("bp%0d:data", i), rsp_data, 32'hA5A5_0F0F);
            chk($sformatf("bp%0d:rd", i), {27'h0, rsp_rd}, 32'd7);
            chk($sformatf("bp%0d:err", i), {31'h0, rsp_err}, 32'd0);
            chk($sformatf("bp%0d:req_ready", i), {31'h0, req_ready}, 32'd0);
            chk($sformatf("bp%0d:busy", i), {31'h0, busy}, 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp:idle_ready", {31'h0, req_ready}, 32'd1);
        chk("bp:idle_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp:second_rd_en", {31'h0, mem_rd_en}, 32'd1);
        chk("bp:second_addr", mem_addr, 32'h0000_3000);
        mem_ack = 1'b1; mem_rdata = 32'hA5A5_0F0F;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("bp:second_data", rsp_data, 32'h0000_000F);
        chk("bp:second_rd", {27'h0, rsp_rd}, 32'd9);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset pulse during WAIT
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_6000; req_size = 2'b10; req_rd = 5'd20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstw:rd_en_before", {31'h0, mem_rd_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw:rd_en", {31'h0, mem_rd_en}, 32'd0);
        chk("rstw:busy", {31'h0, busy}, 32'd0);
        chk("rstw:rsp_valid", {31'h0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_load("lw_after_rst", 32'h0000_2000, 2'b10, 1'b0, 5'd21, 32'hDEAD_BEEF, 0, 1'b0, 32'h2000, 32'hDEAD_BEEF, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
